// File: rtl/register_file_2r1w.sv
// 2-read / 1-write register file with a multi-cycle clear sweep and write mask.
// Optional same-cycle write-to-read bypass when REGFILE_BYPASS_EN is defined.
module register_file_2r1w #(
  parameter int WIDTH  = 32,
  parameter int ADDR_W = 3
) (
  input  logic                      Clk,
  input  logic                      Rst,
  input  logic [ADDR_W-1:0]         R_Addr_A,
  output logic [WIDTH-1:0]          R_Data_A,
  input  logic [ADDR_W-1:0]         R_Addr_B,
  output logic [WIDTH-1:0]          R_Data_B,
  input  logic [ADDR_W-1:0]         W_Addr,
  input  logic                      W_En,
  input  logic [WIDTH-1:0]          W_Data,
  input  logic                      Clr,
  output logic                      Busy,
  output logic                      W_Drop,
  output logic [(2**ADDR_W)-1:0]    Written
);

  localparam int DEPTH = 2 ** ADDR_W;
  localparam logic [ADDR_W-1:0] LAST = ADDR_W'(DEPTH - 1);

  typedef enum logic {
    IDLE,
    SWEEP
  } state_t;

  state_t            state;
  logic [ADDR_W-1:0] ptr;
  logic [WIDTH-1:0]  mem [DEPTH];

  always_ff @(posedge Clk or posedge Rst) begin
    if (Rst) begin
      state   <= IDLE;
      Busy    <= 1'b0;
      ptr     <= '0;
      Written <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        mem[i] <= '0;
      end
    end else begin
      unique case (state)
        IDLE: begin
          if (W_En) begin
            mem[W_Addr]     <= W_Data;
            Written[W_Addr] <= 1'b1;
          end
          if (Clr) begin
            state <= SWEEP;
            Busy  <= 1'b1;
            ptr   <= '0;
          end
        end
        SWEEP: begin
          mem[ptr]     <= '0;
          Written[ptr] <= 1'b0;
          if (ptr == LAST) begin
            state <= IDLE;
            Busy  <= 1'b0;
            ptr   <= '0;
          end else begin
            ptr <= ptr + ADDR_W'(1);
          end
        end
        default: begin
          state <= IDLE;
          Busy  <= 1'b0;
          ptr   <= '0;
        end
      endcase
    end
  end

  assign W_Drop = W_En & Busy;

`ifdef REGFILE_BYPASS_EN
  logic byp_a;
  logic byp_b;

  // Forwarding is suppressed while sweeping since the write is dropped.
  assign byp_a = W_En && !Busy && (R_Addr_A == W_Addr);
  assign byp_b = W_En && !Busy && (R_Addr_B == W_Addr);

  assign R_Data_A = byp_a ? W_Data : mem[R_Addr_A];
  assign R_Data_B = byp_b ? W_Data : mem[R_Addr_B];
`else
  assign R_Data_A = mem[R_Addr_A];
  assign R_Data_B = mem[R_Addr_B];
`endif

endmodule

// File: tb/tb_register_file_2r1w.sv
// Scoreboard bench for register_file_2r1w: stimulus queues expectations,
// a negedge monitor pops and compares them against the live outputs.
module tb_register_file_2r1w;

  localparam int WIDTH  = 32;
  localparam int ADDR_W = 3;
  localparam int DEPTH  = 8;

  logic              clk;
  logic              rst;
  logic [ADDR_W-1:0] r_addr_a;
  logic [WIDTH-1:0]  r_data_a;
  logic [ADDR_W-1:0] r_addr_b;
  logic [WIDTH-1:0]  r_data_b;
  logic [ADDR_W-1:0] w_addr;
  logic              w_en;
  logic [WIDTH-1:0]  w_data;
  logic              clr;
  logic              busy;
  logic              w_drop;
  logic [DEPTH-1:0]  written;

  register_file_2r1w #(
    .WIDTH (WIDTH),
    .ADDR_W(ADDR_W)
  ) dut (
    .Clk     (clk),
    .Rst     (rst),
    .R_Addr_A(r_addr_a),
    .R_Data_A(r_data_a),
    .R_Addr_B(r_addr_b),
    .R_Data_B(r_data_b),
    .W_Addr  (w_addr),
    .W_En    (w_en),
    .W_Data  (w_data),
    .Clr     (clr),
    .Busy    (busy),
    .W_Drop  (w_drop),
    .Written (written)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef enum int {
    K_A,
    K_B,
    K_WR,
    K_BUSY,
    K_DROP
  } kind_t;

  typedef struct {
    kind_t       kind;
    logic [31:0] exp;
    int          step;
  } chk_t;

  chk_t q[$];
  int   errors = 0;
  int   checks = 0;
  int   step   = 0;

  function automatic logic [31:0] actual(kind_t k);
    unique case (k)
      K_A:     return r_data_a;
      K_B:     return r_data_b;
      K_WR:    return 32'(written);
      K_BUSY:  return 32'(busy);
      default: return 32'(w_drop);
    endcase
  endfunction

  function automatic string kname(kind_t k);
    unique case (k)
      K_A:     return "r_data_a";
      K_B:     return "r_data_b";
      K_WR:    return "written";
      K_BUSY:  return "busy";
      default: return "w_drop";
    endcase
  endfunction

  // Monitor: drain everything queued for this cycle once inputs settle.
  initial begin
    forever begin
      @(negedge clk);
      while (q.size() > 0) begin
        chk_t c;
        logic [31:0] act;
        c   = q.pop_front();
        act = actual(c.kind);
        checks++;
        if (act !== c.exp) begin
          errors++;
          $display("FAIL %s step %0d: got %h want %h",
                   kname(c.kind), c.step, act, c.exp);
        end
      end
    end
  end

  task automatic expect_v(kind_t k, logic [31:0] v);
    chk_t c;
    c.kind = k;
    c.exp  = v;
    c.step = step;
    q.push_back(c);
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
    step++;
  endtask

  task automatic idle_in();
    w_en = 1'b0;
    clr  = 1'b0;
  endtask

  task automatic wr(int a, logic [31:0] d);
    w_en   = 1'b1;
    w_addr = ADDR_W'(a);
    w_data = d;
  endtask

  task automatic rd(int a, int b);
    r_addr_a = ADDR_W'(a);
    r_addr_b = ADDR_W'(b);
  endtask

  initial begin
    rst      = 1'b1;
    r_addr_a = '0;
    r_addr_b = '0;
    w_addr   = '0;
    w_en     = 1'b0;
    w_data   = '0;
    clr      = 1'b0;

    // Reset state
    cyc();
    rd(1, 6);
    expect_v(K_A, 32'h0);
    expect_v(K_B, 32'h0);
    expect_v(K_WR, 32'h0);
    expect_v(K_BUSY, 32'h0);
    expect_v(K_DROP, 32'h0);
    cyc();
    rst = 1'b0;

    // Basic writes and dual reads
    wr(5, 32'hDEAD_BEEF);
    cyc();
    wr(2, 32'h0000_1234);
    cyc();
    idle_in();
    rd(5, 2);
    expect_v(K_A, 32'hDEAD_BEEF);
    expect_v(K_B, 32'h0000_1234);
    expect_v(K_WR, 32'h24);
    cyc();
    rd(5, 5);
    expect_v(K_A, 32'hDEAD_BEEF);
    expect_v(K_B, 32'hDEAD_BEEF);

    // Same-cycle write/read of entry 3
    cyc();
    wr(3, 32'hA5A5_A5A5);
    rd(3, 5);
`ifdef REGFILE_BYPASS_EN
    expect_v(K_A, 32'hA5A5_A5A5);
`else
    expect_v(K_A, 32'h0);
`endif
    expect_v(K_B, 32'hDEAD_BEEF);
    expect_v(K_DROP, 32'h0);
    cyc();
    idle_in();
    rd(3, 3);
    expect_v(K_A, 32'hA5A5_A5A5);
    expect_v(K_B, 32'hA5A5_A5A5);
    expect_v(K_WR, 32'h2C);

    // Fill entries with 1..8
    for (int i = 0; i < DEPTH; i++) begin
      cyc();
      wr(i, 32'(i + 1));
    end
    cyc();
    idle_in();
    rd(0, 7);
    expect_v(K_A, 32'h1);
    expect_v(K_B, 32'h8);
    expect_v(K_WR, 32'hFF);
    clr = 1'b1;
    expect_v(K_BUSY, 32'h0);

    // Sweep: j edges into it, entries below j are already cleared
    for (int j = 0; j < DEPTH; j++) begin
      cyc();
      idle_in();
      rd((j == 0) ? 0 : j - 1, j);
      expect_v(K_BUSY, 32'h1);
      expect_v(K_A, (j == 0) ? 32'h1 : 32'h0);
      expect_v(K_B, 32'(j + 1));
      if (j == 2) begin
        wr(4, 32'hFFFF);
        expect_v(K_DROP, 32'h1);
      end else begin
        expect_v(K_DROP, 32'h0);
      end
      if (j == 4) clr = 1'b1;
    end
    cyc();
    idle_in();
    rd(4, 7);
    expect_v(K_BUSY, 32'h0);
    expect_v(K_WR, 32'h0);
    expect_v(K_A, 32'h0);
    expect_v(K_B, 32'h0);
    cyc();
    rd(0, 3);
    expect_v(K_A, 32'h0);
    expect_v(K_B, 32'h0);
    expect_v(K_BUSY, 32'h0);

    // Reset in the middle of a sweep
    wr(7, 32'h99);
    cyc();
    idle_in();
    wr(1, 32'h55);
    cyc();
    idle_in();
    clr = 1'b1;
    cyc();
    clr = 1'b0;
    for (int j = 0; j < 3; j++) cyc();
    rst = 1'b1;
    rd(7, 1);
    expect_v(K_BUSY, 32'h0);
    expect_v(K_WR, 32'h0);
    expect_v(K_A, 32'h0);
    expect_v(K_B, 32'h0);
    expect_v(K_DROP, 32'h0);
    cyc();
    rst = 1'b0;
    wr(6, 32'h77);
    cyc();
    idle_in();
    rd(6, 7);
    expect_v(K_A, 32'h77);
    expect_v(K_B, 32'h0);
    expect_v(K_WR, 32'h40);
    expect_v(K_BUSY, 32'h0);

    @(negedge clk);
    #1;
    if (q.size() != 0) begin
      errors++;
      $display("FAIL scoreboard_drain: got %0d left want 0", q.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
